// File: rtl/gpio_apb_irq_if.sv
// rtl/gpio_apb_irq_if.sv - APB slave bus bundle for the GPIO block
interface gpio_apb_irq_if #(
    parameter int AW = 12
);
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [3:0]    PSTRB;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/gpio_apb_irq.sv
// rtl/gpio_apb_irq.sv - APB GPIO with set/clear aliases, input sync and edge interrupts
module gpio_apb_irq #(
    parameter int AW          = 12,
    parameter int NPIN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NPIN-1:0]  gpio_in,
    output logic [NPIN-1:0]  gpio_out,
    output logic [NPIN-1:0]  gpio_dir,
    output logic             irq0,
    output logic             irq1,
    gpio_apb_irq_if.slave    bus
);
    localparam logic [31:0] ID_VALUE   = {16'h6770, 8'(NPIN), 8'(SYNC_STAGES)};
    localparam logic [3:0]  OFS_OUT    = 4'd0;
    localparam logic [3:0]  OFS_OE     = 4'd1;
    localparam logic [3:0]  OFS_IN     = 4'd2;
    localparam logic [3:0]  OFS_SET    = 4'd3;
    localparam logic [3:0]  OFS_CLR    = 4'd4;
    localparam logic [3:0]  OFS_RISE   = 4'd5;
    localparam logic [3:0]  OFS_FALL   = 4'd6;
    localparam logic [3:0]  OFS_STATUS = 4'd7;
    localparam logic [3:0]  OFS_SEL    = 4'd8;
    localparam logic [3:0]  OFS_ID     = 4'd9;

    logic [NPIN-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q, sel_q, prev_q;
    logic [NPIN-1:0] sync_q [SYNC_STAGES];
    logic [NPIN-1:0] sync_v, rise_v, fall_v, bmask_v, wdata_v, w1c_v;
    logic            access, hit, mapped, err, wr;
    logic [3:0]      idx;
    logic [31:0]     bmask, wmasked, rdata;
    logic            unused;

    assign access  = bus.PSEL & bus.PENABLE;
    assign idx     = bus.PADDR[5:2];
    assign hit     = (bus.PADDR[AW-1:6] == '0);
    assign mapped  = hit && (idx <= OFS_ID);
    assign err     = access && (!mapped || (bus.PWRITE && (idx == OFS_IN || idx == OFS_ID)));
    assign wr      = access && bus.PWRITE && !err;
    assign bmask   = {{8{bus.PSTRB[3]}}, {8{bus.PSTRB[2]}}, {8{bus.PSTRB[1]}}, {8{bus.PSTRB[0]}}};
    assign wmasked = bus.PWDATA & bmask;
    assign bmask_v = bmask[NPIN-1:0];
    assign wdata_v = wmasked[NPIN-1:0];
    assign unused  = ^{bus.PADDR[1:0], bus.PWDATA, bmask};

    assign sync_v = sync_q[SYNC_STAGES-1];
    assign rise_v = sync_v & ~prev_q;
    assign fall_v = ~sync_v & prev_q;
    assign w1c_v  = (wr && idx == OFS_STATUS) ? wdata_v : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // A fresh edge is OR-ed in after the W1C mask, so it wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sel_q     <= '0;
            prev_q    <= '0;
            irq0      <= 1'b0;
            irq1      <= 1'b0;
        end else begin
            prev_q   <= sync_v;
            status_q <= (status_q & ~w1c_v) | (rise_v & rise_en_q) | (fall_v & fall_en_q);
            irq0     <= |(status_q & ~sel_q);
            irq1     <= |(status_q & sel_q);
            if (wr) begin
                case (idx)
                    OFS_OUT:  out_q     <= (out_q & ~bmask_v) | wdata_v;
                    OFS_OE:   oe_q      <= (oe_q & ~bmask_v) | wdata_v;
                    OFS_SET:  out_q     <= out_q | wdata_v;
                    OFS_CLR:  out_q     <= out_q & ~wdata_v;
                    OFS_RISE: rise_en_q <= (rise_en_q & ~bmask_v) | wdata_v;
                    OFS_FALL: fall_en_q <= (fall_en_q & ~bmask_v) | wdata_v;
                    OFS_SEL:  sel_q     <= (sel_q & ~bmask_v) | wdata_v;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            OFS_OUT:    rdata = 32'(out_q);
            OFS_OE:     rdata = 32'(oe_q);
            OFS_IN:     rdata = 32'(sync_v);
            OFS_RISE:   rdata = 32'(rise_en_q);
            OFS_FALL:   rdata = 32'(fall_en_q);
            OFS_STATUS: rdata = 32'(status_q);
            OFS_SEL:    rdata = 32'(sel_q);
            OFS_ID:     rdata = ID_VALUE;
            default:    rdata = '0;
        endcase
    end

    assign bus.PRDATA  = (access && !bus.PWRITE && !err) ? rdata : '0;
    assign bus.PREADY  = 1'b1;
    assign bus.PSLVERR = err;
    assign gpio_out    = out_q;
    assign gpio_dir    = oe_q;
endmodule

// File: tb/tb_gpio_apb_irq.sv
// tb/tb_gpio_apb_irq.sv - randomized model-checked bench for gpio_apb_irq
module tb_gpio_apb_irq;
    localparam int AW = 12;
    localparam int SS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [31:0]   gpio_in;
    logic [7:0]    gpio_in8;
    logic [31:0]   gpio_out, gpio_dir;
    logic [7:0]    gpio_out8, gpio_dir8;
    logic          irq0, irq1, irq0_8, irq1_8;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite, which;
    logic [3:0]    pstrb;
    logic [31:0]   pwdata;
    int            n_chk = 0;
    int            n_err = 0;

    gpio_apb_irq_if #(.AW(AW)) bus0 ();
    gpio_apb_irq_if #(.AW(AW)) bus8 ();

    assign bus0.PADDR = paddr;  assign bus0.PSEL = psel & ~which; assign bus0.PENABLE = penable;
    assign bus0.PWRITE = pwrite; assign bus0.PSTRB = pstrb;       assign bus0.PWDATA = pwdata;
    assign bus8.PADDR = paddr;  assign bus8.PSEL = psel & which;  assign bus8.PENABLE = penable;
    assign bus8.PWRITE = pwrite; assign bus8.PSTRB = pstrb;       assign bus8.PWDATA = pwdata;

    gpio_apb_irq #(.AW(AW), .NPIN(32), .SYNC_STAGES(SS)) dut (
        .clk(clk), .resetn(resetn), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_dir(gpio_dir), .irq0(irq0), .irq1(irq1), .bus(bus0.slave));

    gpio_apb_irq #(.AW(AW), .NPIN(8), .SYNC_STAGES(SS)) dut8 (
        .clk(clk), .resetn(resetn), .gpio_in(gpio_in8), .gpio_out(gpio_out8),
        .gpio_dir(gpio_dir8), .irq0(irq0_8), .irq1(irq1_8), .bus(bus8.slave));

    // Reference model of the 32-pin instance: a sampled-input history stands in for the synchroniser.
    logic [31:0] m_out, m_oe, m_rise, m_fall, m_status, m_sel;
    logic        m_irq0, m_irq1;
    logic [31:0] hist[$];

    function automatic logic model_err(input logic [AW-1:0] a, input logic w);
        int r = int'(a) / 4;
        if (a >= AW'(64) || r > 9) return 1'b1;
        return w && (r == 2 || r == 9);
    endfunction

    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        if (a >= AW'(64)) return 32'h0;
        case (int'(a) / 4)
            0: return m_out;
            1: return m_oe;
            2: return hist[SS-1];
            5: return m_rise;
            6: return m_fall;
            7: return m_status;
            8: return m_sel;
            9: return 32'h6770_2002;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] sy, pv, ev, bm, wm, w1c;
        if (!resetn) begin
            m_out = 0; m_oe = 0; m_rise = 0; m_fall = 0; m_status = 0; m_sel = 0;
            m_irq0 = 0; m_irq1 = 0;
            hist = {};
            for (int i = 0; i <= SS; i++) hist.push_back(32'h0);
        end else begin
            sy = hist[SS-1];
            pv = hist[SS];
            ev = (sy & ~pv & m_rise) | (~sy & pv & m_fall);
            m_irq0 = |(m_status & ~m_sel);
            m_irq1 = |(m_status & m_sel);
            w1c = 0;
            bm = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
            wm = pwdata & bm;
            if (psel && penable && !which && pwrite && !model_err(paddr, 1'b1)) begin
                case (int'(paddr) / 4)
                    0: m_out  = (m_out & ~bm) | wm;
                    1: m_oe   = (m_oe & ~bm) | wm;
                    3: m_out  = m_out | wm;
                    4: m_out  = m_out & ~wm;
                    5: m_rise = (m_rise & ~bm) | wm;
                    6: m_fall = (m_fall & ~bm) | wm;
                    7: w1c    = wm;
                    8: m_sel  = (m_sel & ~bm) | wm;
                    default: ;
                endcase
            end
            m_status = (m_status & ~w1c) | ev;
            hist.push_front(gpio_in);
            void'(hist.pop_back());
        end
    end

    // Entered and left at a falling edge; commit happens at the rising edge in between.
    task automatic apb_xfer(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic er,
                            output logic [31:0] erd, output logic eer);
        paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd  = which ? bus8.PRDATA : bus0.PRDATA;
        er  = which ? bus8.PSLVERR : bus0.PSLVERR;
        erd = w ? 32'h0 : model_rd(a);
        eer = model_err(a, w);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, erd; logic er, eer;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        n_chk++; if (gpio_out !== 0 || gpio_dir !== 0) begin n_err++; $display("FAIL reset_pins got out=%h dir=%h exp 0", gpio_out, gpio_dir); end
        n_chk++; if (irq0 !== 0 || irq1 !== 0) begin n_err++; $display("FAIL reset_irq got %b%b exp 00", irq0, irq1); end
        n_chk++; if (bus0.PREADY !== 1'b1) begin n_err++; $display("FAIL pready got %b exp 1", bus0.PREADY); end
        for (int r = 0; r < 10; r++) begin
            apb_xfer(AW'(r * 4), 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
            n_chk++; if (rd !== ((r == 9) ? 32'h6770_2002 : 32'h0)) begin n_err++; $display("FAIL reset_read off=%0h got=%h exp=%h", r * 4, rd, (r == 9) ? 32'h6770_2002 : 32'h0); end
            n_chk++; if (er !== 1'b0) begin n_err++; $display("FAIL reset_pslverr off=%0h got=%b exp=0", r * 4, er); end
        end
    endtask

    task automatic test_out_regs();
        logic [31:0] rd, erd; logic er, eer;
        apb_xfer(12'h000, 1'b1, 32'h0000_00F0, 4'b0001, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL write_prdata got=%h err=%b exp 0/0", rd, er); end
        apb_xfer(12'h00C, 1'b1, 32'h3, 4'hF, rd, er, erd, eer);
        apb_xfer(12'h010, 1'b1, 32'h10, 4'hF, rd, er, erd, eer);
        apb_xfer(12'h004, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, erd, eer);
        n_chk++; if (gpio_out !== 32'h0000_00E3) begin n_err++; $display("FAIL gpio_out got=%h exp=000000e3", gpio_out); end
        n_chk++; if (gpio_dir !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL gpio_dir got=%h exp=ffffffff", gpio_dir); end
        apb_xfer(12'h000, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h0000_00E3) begin n_err++; $display("FAIL out_read got=%h exp=000000e3", rd); end
        apb_xfer(12'h004, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL oe_read got=%h exp=ffffffff", rd); end
        apb_xfer(12'h00C, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL wo_read got=%h err=%b exp 0/0", rd, er); end
    endtask

    task automatic test_rise_irq();
        logic [31:0] rd, erd; logic er, eer;
        apb_xfer(12'h014, 1'b1, 32'h20, 4'hF, rd, er, erd, eer);
        apb_xfer(12'h020, 1'b1, 32'h0, 4'hF, rd, er, erd, eer);
        gpio_in[5] = 1'b1;
        @(negedge clk);
        apb_xfer(12'h008, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd[5] !== 1'b1 || rd !== erd) begin n_err++; $display("FAIL in_latency got=%h exp=%h", rd, erd); end
        n_chk++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq0_early got=%b exp=0", irq0); end
        @(negedge clk);
        n_chk++; if (irq0 !== 1'b1 || irq1 !== 1'b0) begin n_err++; $display("FAIL irq0_rise got=%b%b exp=10", irq0, irq1); end
        apb_xfer(12'h01C, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h20) begin n_err++; $display("FAIL status_rise got=%h exp=00000020", rd); end
        apb_xfer(12'h01C, 1'b1, 32'h20, 4'hF, rd, er, erd, eer);
        n_chk++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL irq0_hold got=%b exp=1", irq0); end
        @(negedge clk);
        n_chk++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq0_clear got=%b exp=0", irq0); end
    endtask

    task automatic test_fall_w1c_race();
        logic [31:0] rd, erd; logic er, eer;
        apb_xfer(12'h018, 1'b1, 32'h80, 4'hF, rd, er, erd, eer);
        apb_xfer(12'h020, 1'b1, 32'h80, 4'hF, rd, er, erd, eer);
        gpio_in[7] = 1'b1; repeat (5) @(negedge clk);
        gpio_in[7] = 1'b0; repeat (5) @(negedge clk);
        n_chk++; if (irq1 !== 1'b1 || irq0 !== 1'b0) begin n_err++; $display("FAIL irq1_fall got=%b%b exp=01", irq0, irq1); end
        gpio_in[7] = 1'b1; repeat (5) @(negedge clk);
        gpio_in[7] = 1'b0;
        @(negedge clk);
        apb_xfer(12'h01C, 1'b1, 32'h80, 4'hF, rd, er, erd, eer);
        apb_xfer(12'h01C, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h80 || rd !== erd) begin n_err++; $display("FAIL edge_beats_w1c got=%h exp=00000080", rd); end
        n_chk++; if (irq1 !== 1'b1) begin n_err++; $display("FAIL irq1_race got=%b exp=1", irq1); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer;
        logic [AW-1:0] bad [5] = '{12'h028, 12'h008, 12'h024, 12'h040, 12'h800};
        logic          bw  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            apb_xfer(bad[i], bw[i], 32'hFFFF_FFFF, 4'hF, rd, er, erd, eer);
            n_chk++; if (er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL pslverr addr=%h got err=%b rd=%h exp 1/0", bad[i], er, rd); end
        end
        for (int r = 0; r < 10; r++) begin
            apb_xfer(AW'(r * 4), 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
            n_chk++; if (rd !== erd) begin n_err++; $display("FAIL err_nochange off=%0h got=%h exp=%h", r * 4, rd, erd); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd; logic er, eer;
        for (int it = 0; it < 300; it++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ ($urandom & $urandom & $urandom);
            a = AW'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a[AW-1] = 1'b1;
            apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, er, erd, eer);
            n_chk++; if (rd !== erd || er !== eer) begin n_err++; $display("FAIL rnd_bus it=%0d addr=%h got=%h/%b exp=%h/%b", it, a, rd, er, erd, eer); end
            n_chk++; if (gpio_out !== m_out || gpio_dir !== m_oe) begin n_err++; $display("FAIL rnd_pins it=%0d got=%h/%h exp=%h/%h", it, gpio_out, gpio_dir, m_out, m_oe); end
            n_chk++; if (irq0 !== m_irq0 || irq1 !== m_irq1) begin n_err++; $display("FAIL rnd_irq it=%0d got=%b%b exp=%b%b", it, irq0, irq1, m_irq0, m_irq1); end
        end
    endtask

    task automatic test_npin8();
        logic [31:0] rd, erd; logic er, eer;
        which = 1'b1;
        apb_xfer(12'h000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, erd, eer);
        apb_xfer(12'h000, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h0000_00FF || gpio_out8 !== 8'hFF) begin n_err++; $display("FAIL npin8_out got=%h pins=%h exp=000000ff", rd, gpio_out8); end
        apb_xfer(12'h024, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h6770_0802) begin n_err++; $display("FAIL npin8_id got=%h exp=67700802", rd); end
        paddr = 12'h000; pwrite = 1'b1; pwdata = 32'hAB; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1; resetn = 1'b0;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; resetn = 1'b1;
        apb_xfer(12'h000, 1'b0, 32'h0, 4'h0, rd, er, erd, eer);
        n_chk++; if (rd !== 32'h0 || gpio_out8 !== 8'h0) begin n_err++; $display("FAIL reset_mid_write got=%h pins=%h exp=0", rd, gpio_out8); end
        n_chk++; if (gpio_out !== 32'h0 || irq0 !== 1'b0 || irq1 !== 1'b0) begin n_err++; $display("FAIL reset_main got=%h irq=%b%b exp=0", gpio_out, irq0, irq1); end
        which = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; gpio_in = '0; gpio_in8 = '0; which = 1'b0;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0; pwdata = '0;
        @(negedge clk);
        test_reset();
        test_out_regs();
        test_rise_irq();
        test_fall_w1c_race();
        test_errors();
        test_random();
        test_npin8();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
